// File: rtl/z80bm_pkg.sv
// Shared definitions for the Z80 bus master: command op encoding, bus-cycle
// state enum and op decode helpers.
package z80bm_pkg;

  localparam logic [1:0] OP_MEM_RD = 2'd0;
  localparam logic [1:0] OP_MEM_WR = 2'd1;
  localparam logic [1:0] OP_IO_RD  = 2'd2;
  localparam logic [1:0] OP_IO_WR  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    T1,
    T2,
    TWA,
    TW,
    T3,
    DONE
  } state_t;

  function automatic logic is_io(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic is_wr(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/z80bm_tick.sv
// T-state prescaler: tick is high on the last system clock of each T-state;
// clr restarts the T-state so the first one after a command is full length.
module z80bm_tick #(
  parameter int CLK_DIV = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/z80_bus_master.sv
// Z80 bus initiator: turns single-beat commands into T-state timed bus cycles.
// Define Z80BM_WAIT_TIMEOUT_EN to abort a cycle after WAIT_TIMEOUT TW states.
module z80_bus_master
  import z80bm_pkg::*;
#(
  parameter int CLK_DIV = 6
`ifdef Z80BM_WAIT_TIMEOUT_EN
  , parameter int WAIT_TIMEOUT = 1024
`endif
) (
  input  logic        CLK_24MHz,
  input  logic        RES,
  // cmd: a command transfers in any cycle where cmd_valid && cmd_ready.
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] A,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [7:0]  D_in,
  output logic        MREQ,
  output logic        IORQ,
  output logic        RD,
  output logic        WR,
  input  logic        WAIT,
  output state_t      dbg_state
);

  state_t     state;
  logic [1:0] op_q;
  logic       wait_q1, wait_q2;
  logic       tick;
  logic       accept;

  assign accept    = cmd_valid && cmd_ready;
  assign dbg_state = state;

  z80bm_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (CLK_24MHz),
    .rst_n (RES),
    .clr   (accept),
    .tick  (tick)
  );

  // WAIT is asynchronous to the CPLD clock; idle level is high.
  always_ff @(posedge CLK_24MHz or negedge RES) begin
    if (!RES) begin
      wait_q1 <= 1'b1;
      wait_q2 <= 1'b1;
    end else begin
      wait_q1 <= WAIT;
      wait_q2 <= wait_q1;
    end
  end

`ifdef Z80BM_WAIT_TIMEOUT_EN
  localparam int TW_W = $clog2(WAIT_TIMEOUT + 1);
  logic [TW_W-1:0] tw_cnt;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge CLK_24MHz or negedge RES) begin
    if (!RES) begin
      state     <= IDLE;
      op_q      <= OP_MEM_RD;
      A         <= '0;
      D_out     <= '0;
      D_oe      <= 1'b0;
      MREQ      <= 1'b1;
      IORQ      <= 1'b1;
      RD        <= 1'b1;
      WR        <= 1'b1;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef Z80BM_WAIT_TIMEOUT_EN
      rsp_err   <= 1'b0;
      tw_cnt    <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= cmd_op;
            A         <= cmd_addr;
            cmd_ready <= 1'b0;
            if (is_wr(cmd_op)) begin
              D_out <= cmd_wdata;
              D_oe  <= 1'b1;
            end
`ifdef Z80BM_WAIT_TIMEOUT_EN
            rsp_err <= 1'b0;
`endif
            state <= T1;
          end
        end
        T1: begin
          if (tick) begin
            MREQ  <= is_io(op_q);
            IORQ  <= !is_io(op_q);
            RD    <= is_wr(op_q);
            WR    <= !is_wr(op_q);
`ifdef Z80BM_WAIT_TIMEOUT_EN
            tw_cnt <= '0;
`endif
            state <= T2;
          end
        end
        T2: begin
          if (tick) begin
            if (is_io(op_q)) state <= TWA;
            else if (!wait_q2) state <= TW;
            else state <= T3;
          end
        end
        TWA: begin
          if (tick) state <= wait_q2 ? T3 : TW;
        end
        TW: begin
          if (tick && wait_q2) begin
            state <= T3;
          end
`ifdef Z80BM_WAIT_TIMEOUT_EN
          else if (tick) begin
            if (tw_cnt == TW_W'(WAIT_TIMEOUT - 1)) begin
              MREQ      <= 1'b1;
              IORQ      <= 1'b1;
              RD        <= 1'b1;
              WR        <= 1'b1;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              if (!is_wr(op_q)) rsp_rdata <= 8'hFF;
              state     <= DONE;
            end else begin
              tw_cnt <= tw_cnt + TW_W'(1);
            end
          end
`endif
        end
        T3: begin
          if (tick) begin
            if (!is_wr(op_q)) rsp_rdata <= D_in;
            MREQ      <= 1'b1;
            IORQ      <= 1'b1;
            RD        <= 1'b1;
            WR        <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // A stays on the bus through idle; only the data driver is released.
          D_oe      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_bus_master.sv
// Bench for z80_bus_master: directed and random bus cycles checked against a
// latency/strobe-width model derived from the T-state rules.
module tb_z80_bus_master;
  import z80bm_pkg::*;

  localparam int CLK_DIV = 6;
`ifdef Z80BM_WAIT_TIMEOUT_EN
  localparam int TW_LIMIT = 4;
`endif

  logic        CLK_24MHz;
  logic        RES;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [15:0] A;
  logic [7:0]  D_out;
  logic        D_oe;
  logic [7:0]  D_in;
  logic        MREQ, IORQ, RD, WR;
  logic        WAIT;
  state_t      dbg_state;

  int n_pass;
  int n_total;

  z80_bus_master #(
    .CLK_DIV(CLK_DIV)
`ifdef Z80BM_WAIT_TIMEOUT_EN
    , .WAIT_TIMEOUT(TW_LIMIT)
`endif
  ) dut (
    .CLK_24MHz (CLK_24MHz),
    .RES       (RES),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .A         (A),
    .D_out     (D_out),
    .D_oe      (D_oe),
    .D_in      (D_in),
    .MREQ      (MREQ),
    .IORQ      (IORQ),
    .RD        (RD),
    .WR        (WR),
    .WAIT      (WAIT),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial CLK_24MHz = 1'b0;
  always #5 CLK_24MHz = ~CLK_24MHz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: number of TW states actually executed
  function automatic int model_tw(input int n_wait);
`ifdef Z80BM_WAIT_TIMEOUT_EN
    if (n_wait >= TW_LIMIT) return TW_LIMIT;
`endif
    return n_wait;
  endfunction

  function automatic bit model_err(input int n_wait);
`ifdef Z80BM_WAIT_TIMEOUT_EN
    if (n_wait >= TW_LIMIT) return 1'b1;
`endif
    return (n_wait < 0);
  endfunction

  // Cycles from accept to rsp_valid: T1,T2,(TWA),T3 plus TW states; an
  // aborted cycle skips T3.
  function automatic int model_latency(input logic [1:0] op, input int n_wait);
    int tstates;
    tstates = (op == OP_IO_RD || op == OP_IO_WR) ? 4 : 3;
    tstates = tstates + model_tw(n_wait);
    if (model_err(n_wait)) tstates = tstates - 1;
    return tstates * CLK_DIV;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_A"}, 32'(A), 32'h0);
    check({tag, "_dout"}, 32'(D_out), 32'h0);
    check({tag, "_doe"}, 32'(D_oe), 32'h0);
    check({tag, "_strobes"}, 32'({MREQ, IORQ, RD, WR}), 32'hF);
    check({tag, "_ready"}, 32'(cmd_ready), 32'h1);
    check({tag, "_rsp"}, 32'({rsp_valid, rsp_err, rsp_rdata}), 32'h0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // Driver: one command, called at a falling edge with the block idle.
  // n_wait = number of T-states WAIT is held low, starting at the T-state
  // whose closing tick first samples it (T2 for memory, TWA for IO).
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [15:0] addr,
                         input logic [7:0] wdata, input logic [7:0] din, input int n_wait);
    bit   rd_op;
    bit   io_op;
    int   lat;
    int   ws;
    int   k_rsp;
    int   n_mreq, n_iorq, n_rd, n_wr, n_viol;
    logic [7:0] got_rdata;
    logic got_err;
    rd_op  = (op == OP_MEM_RD || op == OP_IO_RD);
    io_op  = (op == OP_IO_RD || op == OP_IO_WR);
    lat    = model_latency(op, n_wait);
    ws     = io_op ? 2 * CLK_DIV : CLK_DIV;
    k_rsp  = -1;
    n_mreq = 0; n_iorq = 0; n_rd = 0; n_wr = 0; n_viol = 0;
    got_rdata = '0;
    got_err   = 1'b0;

    check({tag, "_ready_idle"}, 32'(cmd_ready), 32'h1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    D_in      = din;
    for (int k = 0; k < 400; k++) begin
      @(negedge CLK_24MHz);
      if (k == 0) begin
        cmd_valid = 1'b0;
        cmd_addr  = 16'($urandom);
        cmd_wdata = 8'($urandom);
        check({tag, "_t1_A"}, 32'(A), 32'(addr));
        check({tag, "_t1_doe"}, 32'(D_oe), 32'(!rd_op));
        if (!rd_op) check({tag, "_t1_dout"}, 32'(D_out), 32'(wdata));
        check({tag, "_t1_strobes"}, 32'({MREQ, IORQ, RD, WR}), 32'hF);
        check({tag, "_busy"}, 32'(cmd_ready), 32'h0);
      end
      if (!MREQ) n_mreq++;
      if (!IORQ) n_iorq++;
      if (!RD) n_rd++;
      if (!WR) n_wr++;
      if ((!MREQ && !IORQ) || (!RD && !WR) || (D_oe && rd_op) || (A !== addr)) n_viol++;
      if (rsp_valid) begin
        k_rsp     = k;
        got_rdata = rsp_rdata;
        got_err   = rsp_err;
        break;
      end
      WAIT = !(n_wait > 0 && k >= ws && k < ws + n_wait * CLK_DIV);
    end
    WAIT = 1'b1;

    check({tag, "_latency"}, 32'(k_rsp), 32'(lat));
    check({tag, "_mem_strobe_cycles"}, 32'(n_mreq), 32'(io_op ? 0 : lat - CLK_DIV));
    check({tag, "_io_strobe_cycles"}, 32'(n_iorq), 32'(io_op ? lat - CLK_DIV : 0));
    check({tag, "_rd_cycles"}, 32'(n_rd), 32'(rd_op ? lat - CLK_DIV : 0));
    check({tag, "_wr_cycles"}, 32'(n_wr), 32'(rd_op ? 0 : lat - CLK_DIV));
    check({tag, "_bus_rules"}, 32'(n_viol), 32'h0);
    check({tag, "_err"}, 32'(got_err), 32'(model_err(n_wait)));
    if (rd_op) check({tag, "_rdata"}, 32'(got_rdata), 32'(model_err(n_wait) ? 8'hFF : din));

    @(negedge CLK_24MHz);
    check({tag, "_rsp_pulse"}, 32'(rsp_valid), 32'h0);
    check({tag, "_idle_ready"}, 32'(cmd_ready), 32'h1);
    check({tag, "_idle_doe"}, 32'(D_oe), 32'h0);
    check({tag, "_idle_A"}, 32'(A), 32'(addr));
    check({tag, "_idle_strobes"}, 32'({MREQ, IORQ, RD, WR}), 32'hF);
  endtask

  initial begin
    int k1, k2, n_ready_busy, n_rsp;
    n_pass    = 0;
    n_total   = 0;
    RES       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_MEM_RD;
    cmd_addr  = '0;
    cmd_wdata = '0;
    D_in      = '0;
    WAIT      = 1'b1;

    #23;
    check_reset_vals("reset");
    @(negedge CLK_24MHz);
    RES = 1'b1;
    @(negedge CLK_24MHz);

    run_cmd("io_wr_page", OP_IO_WR, 16'h0010, 8'h01, 8'h00, 0);
    run_cmd("mem_rd", OP_MEM_RD, 16'h4000, 8'h00, 8'hA5, 0);
    run_cmd("mem_wr_wait2", OP_MEM_WR, 16'h8000, 8'h5A, 8'h00, 2);

    // Back-to-back: cmd_valid held high across two IO writes
    cmd_valid = 1'b1;
    cmd_op    = OP_IO_WR;
    cmd_addr  = 16'h0010;
    cmd_wdata = 8'h01;
    k1 = -1;
    n_ready_busy = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK_24MHz);
      if (rsp_valid) begin
        k1 = k;
        break;
      end
      if (cmd_ready) n_ready_busy++;
    end
    check("b2b_first_latency", 32'(k1), 32'(4 * CLK_DIV));
    check("b2b_no_reaccept", 32'(n_ready_busy), 32'h0);
    cmd_addr  = 16'h0011;
    cmd_wdata = 8'h02;
    @(negedge CLK_24MHz);
    check("b2b_gap_ready", 32'(cmd_ready), 32'h1);
    check("b2b_gap_strobes", 32'({MREQ, IORQ, RD, WR}), 32'hF);
    check("b2b_gap_A", 32'(A), 32'h0010);
    @(negedge CLK_24MHz);
    cmd_valid = 1'b0;
    check("b2b_second_A", 32'(A), 32'h0011);
    check("b2b_second_dout", 32'(D_out), 32'h02);
    check("b2b_second_busy", 32'(cmd_ready), 32'h0);
    k2 = -1;
    for (int k = 1; k < 200; k++) begin
      @(negedge CLK_24MHz);
      if (rsp_valid) begin
        k2 = k;
        break;
      end
    end
    check("b2b_second_latency", 32'(k2), 32'(4 * CLK_DIV));
    @(negedge CLK_24MHz);

    // Reset in the middle of a waited IO read
    cmd_valid = 1'b1;
    cmd_op    = OP_IO_RD;
    cmd_addr  = 16'h0020;
    @(negedge CLK_24MHz);
    cmd_valid = 1'b0;
    WAIT      = 1'b0;
    repeat (4 * CLK_DIV) @(negedge CLK_24MHz);
    check("midrst_in_tw", 32'(dbg_state), 32'(TW));
    #2 RES = 1'b0;
    #1 check_reset_vals("midrst");
    WAIT = 1'b1;
    @(negedge CLK_24MHz);
    RES   = 1'b1;
    n_rsp = 0;
    repeat (10 * CLK_DIV) begin
      @(negedge CLK_24MHz);
      if (rsp_valid) n_rsp++;
    end
    check("midrst_no_rsp", 32'(n_rsp), 32'h0);
    run_cmd("after_rst", OP_IO_RD, 16'h0020, 8'h00, 8'h77, 0);

    // Random commands
    for (int i = 0; i < 20; i++) begin
      run_cmd($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), 16'($urandom),
              8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
    end

`ifdef Z80BM_WAIT_TIMEOUT_EN
    run_cmd("timeout_rd", OP_MEM_RD, 16'h1234, 8'h00, 8'h3C, 50);
    run_cmd("after_timeout", OP_MEM_WR, 16'h1235, 8'hC3, 8'h00, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
